leiwand_rv32_wb_interconnect: RTL
=================================

Name: leiwand_rv32_wb_interconnect

Overview:
Single-master Wishbone interconnect between leiwand_rv32_core and two leiwand_rv32_ram slaves: an internal SRAM and an internal ROM.
- Decodes the core address and drives one strobe per slave.
- Sequences each transaction through an FSM and returns exactly one ack/data (or error) to the core.
- Times out hung slaves.
- Replaces the ad-hoc strobe decode and the shared ack/data wiring in the core testbench.

Parameters:
MEM_WIDTH, 32, address/data width
MEMORY_SIZE, 128, words per slave
SRAM_BASE, 32'h10000000, SRAM byte base address
ROM_BASE, 32'h20000000, ROM byte base address
TIMEOUT_CYCLES, 16, max cycles in REQ+WAIT before bus error (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_cyc  in  1  core bus cycle / request
m_we  in  1  core write enable
m_addr  in  MEM_WIDTH  core byte address
m_data_w  in  MEM_WIDTH  core write data
m_ack  out  1  one-cycle completion pulse to core
m_data_r  out  MEM_WIDTH  read data, valid with m_ack
m_stall  out  1  interconnect busy
m_err  out  1  one-cycle bus-error pulse
s_cyc  out  1  shared slave cycle
s_we  out  1  shared slave write enable
s_addr  out  MEM_WIDTH  latched address, byte offset from selected base
s_data_w  out  MEM_WIDTH  latched write data
sram_stb  out  1  SRAM strobe
sram_ack  in  1  SRAM ack
sram_data_r  in  MEM_WIDTH  SRAM read data
sram_stall  in  1  SRAM stall
rom_stb  out  1  ROM strobe
rom_ack  in  1  ROM ack
rom_data_r  in  MEM_WIDTH  ROM read data
rom_stall  in  1  ROM stall
err_count  out  8  saturating bus-error count
err_addr  out  MEM_WIDTH  address of most recent error

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state IDLE; timeout counter 0. All outputs are 0: m_ack, m_err, m_stall, m_data_r, s_*, *_stb, err_count, err_addr. Reset mid-transaction abandons the transaction silently; no ack and no err is issued.
- Decode: SRAM hit if SRAM_BASE <= addr < SRAM_BASE+4*MEMORY_SIZE; ROM hit likewise with ROM_BASE. Comparisons are unsigned, full width. Use no wrap-around arithmetic; the upper bound is computed at MEM_WIDTH+1 bits.
- IDLE: m_stall=0. If m_cyc=1:
  - Latch addr/we/data/select.
  - Unmapped address, or ROM with m_we=1 -> ERR.
  - Otherwise -> REQ.
  - m_stall=1 from the next cycle until return to IDLE.
- REQ: s_cyc=1; selected stb=1; the other stb=0.
  - Selected stall=0 -> strobe accepted; go to WAIT.
  - If the selected ack is also 1 in that cycle, capture data and go directly to RESP.
- WAIT: s_cyc=1; stb=0. On selected ack=1, capture its data and go to RESP.
- Acks from the non-selected slave are ignored in all states.
- RESP: m_ack=1 for exactly 1 cycle; m_data_r = captured data (0 for writes); s_cyc=0; then IDLE.
  - Minimum latency with an ack-in-REQ slave: m_cyc sampled at edge N, m_ack high in cycle N+2.
  - If m_cyc is still 1 in IDLE afterwards, it starts a new transaction.
- ERR: m_err=1 for 1 cycle; m_ack=0; m_data_r=0; s_cyc=0.
  - err_addr <= latched addr; err_count increments, saturating at 255.
  - Then IDLE.
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES-1 without an ack, go to ERR. An ack arriving in that same cycle wins (RESP).
- Abort: m_cyc=0 in REQ or WAIT -> IDLE next cycle; s_cyc and stb drop; no ack, no err, no counter change.
- m_ack and m_err are never both 1.

Test Plan:
- SRAM read at 0x10000010, slave acks 1 cycle after stb -> sram_stb 1 cycle, s_addr=0x10, m_ack pulse with m_data_r=sram_data_r (0xDEADBEEF), m_stall 1 during transaction.
- ROM write at 0x20000004 -> no rom_stb; m_err pulse 2 cycles after request; err_addr=0x20000004; err_count=1.
- Read at unmapped 0x30000000, then 0x10000200 (first address past SRAM) -> m_err each time; err_count=2.
- SRAM with sram_stall=1 for 3 cycles, then ack -> stb held 4 cycles; single m_ack; rom_ack pulsed mid-transaction is ignored.
- SRAM never acks, TIMEOUT_CYCLES=16 -> m_err after 16 cycles in REQ/WAIT; s_cyc drops; next transaction succeeds normally.
- Core drops m_cyc during WAIT, and reset is asserted during REQ -> no m_ack/m_err; back in IDLE with m_stall=0; err_count unchanged, or 0 after reset.

Source files
------------

// File: rtl/leiwand_rv32_wb_interconnect_if.sv
// Wishbone signal bundle between the core, the interconnect and the SRAM/ROM slaves.
// The interconnect is the core's slave, so it uses the "slave" modport; the environment uses "master".
interface leiwand_rv32_wb_interconnect_if #(
    parameter int MEM_WIDTH = 32
);
    logic                 m_cyc;
    logic                 m_we;
    logic [MEM_WIDTH-1:0] m_addr;
    logic [MEM_WIDTH-1:0] m_data_w;
    logic                 m_ack;
    logic [MEM_WIDTH-1:0] m_data_r;
    logic                 m_stall;
    logic                 m_err;

    logic                 s_cyc;
    logic                 s_we;
    logic [MEM_WIDTH-1:0] s_addr;
    logic [MEM_WIDTH-1:0] s_data_w;

    logic                 sram_stb;
    logic                 sram_ack;
    logic [MEM_WIDTH-1:0] sram_data_r;
    logic                 sram_stall;
    logic                 rom_stb;
    logic                 rom_ack;
    logic [MEM_WIDTH-1:0] rom_data_r;
    logic                 rom_stall;

    modport slave (
        input  m_cyc, m_we, m_addr, m_data_w,
        output m_ack, m_data_r, m_stall, m_err,
        output s_cyc, s_we, s_addr, s_data_w,
        output sram_stb, rom_stb,
        input  sram_ack, sram_data_r, sram_stall,
        input  rom_ack, rom_data_r, rom_stall
    );

    modport master (
        output m_cyc, m_we, m_addr, m_data_w,
        input  m_ack, m_data_r, m_stall, m_err,
        input  s_cyc, s_we, s_addr, s_data_w,
        input  sram_stb, rom_stb,
        output sram_ack, sram_data_r, sram_stall,
        output rom_ack, rom_data_r, rom_stall
    );
endinterface

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Single-master Wishbone interconnect: decodes core requests onto SRAM/ROM, sequences
// one transaction at a time, and converts slave hangs and illegal accesses into bus errors.
module leiwand_rv32_wb_interconnect #(
    parameter int                   MEM_WIDTH      = 32,
    parameter int                   MEMORY_SIZE    = 128,
    parameter logic [MEM_WIDTH-1:0] SRAM_BASE      = 32'h1000_0000,
    parameter logic [MEM_WIDTH-1:0] ROM_BASE       = 32'h2000_0000,
    parameter int                   TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    leiwand_rv32_wb_interconnect_if.slave bus,
    output logic [7:0]           err_count,
    output logic [MEM_WIDTH-1:0] err_addr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    // One extra bit keeps base+span from wrapping near the top of the address space.
    localparam logic [MEM_WIDTH:0] SPAN = (MEM_WIDTH+1)'(4 * MEMORY_SIZE);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;
    state_t state, state_nx;

    logic [MEM_WIDTH:0]   addr_x;
    logic                 hit_sram, hit_rom;
    logic                 sel_rom, lat_we;
    logic [MEM_WIDTH-1:0] lat_addr, lat_off, lat_data, cap_data;
    logic [TW-1:0]        tmr;
    logic                 tmr_end;
    logic                 sel_ack, sel_stall;
    logic [MEM_WIDTH-1:0] sel_data;

    assign addr_x   = {1'b0, bus.m_addr};
    assign hit_sram = (addr_x >= {1'b0, SRAM_BASE}) && (addr_x < ({1'b0, SRAM_BASE} + SPAN));
    assign hit_rom  = (addr_x >= {1'b0, ROM_BASE})  && (addr_x < ({1'b0, ROM_BASE}  + SPAN));

    assign sel_ack   = sel_rom ? bus.rom_ack     : bus.sram_ack;
    assign sel_stall = sel_rom ? bus.rom_stall   : bus.sram_stall;
    assign sel_data  = sel_rom ? bus.rom_data_r  : bus.sram_data_r;
    assign tmr_end   = (tmr == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.m_cyc)
                      state_nx = (!(hit_sram || hit_rom) || (hit_rom && bus.m_we)) ? ERR : REQ;
            // Abort outranks everything; an ack in the last timeout cycle still wins over ERR.
            REQ:  if (!bus.m_cyc)                  state_nx = IDLE;
                  else if (!sel_stall && sel_ack)  state_nx = RESP;
                  else if (tmr_end)                state_nx = ERR;
                  else if (!sel_stall)             state_nx = WAIT;
            WAIT: if (!bus.m_cyc)                  state_nx = IDLE;
                  else if (sel_ack)                state_nx = RESP;
                  else if (tmr_end)                state_nx = ERR;
            RESP:                                  state_nx = IDLE;
            ERR:                                   state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    assign bus.m_ack    = (state == RESP);
    assign bus.m_err    = (state == ERR);
    assign bus.m_stall  = (state != IDLE);
    assign bus.m_data_r = (state == RESP && !lat_we) ? cap_data : '0;
    assign bus.s_cyc    = (state == REQ) || (state == WAIT);
    assign bus.s_we     = lat_we;
    assign bus.s_addr   = lat_off;
    assign bus.s_data_w = lat_data;
    assign bus.sram_stb = (state == REQ) && !sel_rom;
    assign bus.rom_stb  = (state == REQ) &&  sel_rom;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmr       <= '0;
            sel_rom   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_off   <= '0;
            lat_data  <= '0;
            cap_data  <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.m_cyc) begin
                sel_rom  <= hit_rom;
                lat_we   <= bus.m_we;
                lat_addr <= bus.m_addr;
                lat_data <= bus.m_data_w;
                lat_off  <= hit_rom  ? bus.m_addr - ROM_BASE :
                            hit_sram ? bus.m_addr - SRAM_BASE : '0;
            end
            // Counter only moves while staying in REQ/WAIT, so aborts leave it untouched.
            if (state == IDLE && state_nx == REQ)
                tmr <= '0;
            else if ((state == REQ || state == WAIT) && (state_nx == REQ || state_nx == WAIT))
                tmr <= tmr + 1'b1;
            if (state != RESP && state_nx == RESP)
                cap_data <= sel_data;
            if (state == ERR) begin
                err_addr <= lat_addr;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end
endmodule
